// File: rtl/pad_boot_sequencer.sv
// pad_boot_sequencer: boot/run-control sequencer between the pad ring and the core.
//   Holds core reset for a fixed period, then waits for the fetch-enable pad and an idle
//   SPI-slave chip select. After a programmable quiet delay it asserts core fetch enable,
//   then watches end-of-computation and an optional watchdog to give sticky pad status.
// Optional feature macro: BOOT_SEQ_WDT_EN (watchdog compare and RUN counter).
//   When undefined, wdt_limit_i is ignored, TIMEOUT is unreachable and timeout_o is 0.
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   fetch_en_pad_i  - fetch-enable pad (asynchronous, 2-flop synchronised)
//   spi_cs_n_i      - SPI-slave chip select pad (asynchronous, 2-flop synchronised, low = loading)
//   eoc_i           - end of computation from core gpio_out[8] (clk domain, used in RUN only)
//   wdt_limit_i     - watchdog limit in RUN cycles, 0 disables
//   core_rst_n_o    - registered reset to core/peripherals
//   fetch_enable_o  - registered fetch enable to core
//   eoc_o           - sticky end of computation
//   timeout_o       - sticky watchdog expiry
//   state_o         - current state encoding
module pad_boot_sequencer #(
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int FETCH_DELAY_CYCLES = 500,
  parameter int WDT_WIDTH          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en_pad_i,
  input  logic                 spi_cs_n_i,
  input  logic                 eoc_i,
  input  logic [WDT_WIDTH-1:0] wdt_limit_i,
  output logic                 core_rst_n_o,
  output logic                 fetch_enable_o,
  output logic                 eoc_o,
  output logic                 timeout_o,
  output logic [2:0]           state_o
);

  // One shared counter, wide enough for every phase that uses it.
  localparam int RH_W  = $clog2(RST_HOLD_CYCLES + 1);
  localparam int FD_W  = $clog2(FETCH_DELAY_CYCLES + 1);
  localparam int RF_W  = (RH_W > FD_W) ? RH_W : FD_W;
  localparam int CNT_W = (WDT_WIDTH > RF_W) ? WDT_WIDTH : RF_W;

  localparam logic [CNT_W-1:0] RH_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FD_LAST = CNT_W'(FETCH_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_RST_HOLD    = 3'd0,
    ST_WAIT_LOAD   = 3'd1,
    ST_FETCH_DELAY = 3'd2,
    ST_RUN         = 3'd3,
    ST_DONE        = 3'd4,
    ST_TIMEOUT     = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic fen_q1, fen_s;
  logic csn_q1, csn_s;
  logic wdt_hit;

  // Pad synchronisers. Reset values represent "not enabled" and "loader idle".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fen_q1 <= 1'b0;
      fen_s  <= 1'b0;
      csn_q1 <= 1'b1;
      csn_s  <= 1'b1;
    end else begin
      fen_q1 <= fetch_en_pad_i;
      fen_s  <= fen_q1;
      csn_q1 <= spi_cs_n_i;
      csn_s  <= csn_q1;
    end
  end

`ifdef BOOT_SEQ_WDT_EN
  // cnt holds the number of completed RUN cycles; the hit fires on the edge that
  // completes wdt_limit_i of them. The limit is re-read every cycle.
  logic [CNT_W-1:0] wdt_last;
  assign wdt_last = CNT_W'(wdt_limit_i) - CNT_ONE;
  assign wdt_hit  = (wdt_limit_i != '0) && (cnt == wdt_last);
`else
  logic unused_wdt;
  assign unused_wdt = ^wdt_limit_i;
  assign wdt_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RST_HOLD: begin
        if (cnt == RH_LAST) state_nxt = ST_WAIT_LOAD;
      end
      ST_WAIT_LOAD: begin
        if (fen_s && csn_s) state_nxt = ST_FETCH_DELAY;
      end
      ST_FETCH_DELAY: begin
        // Loader activity or fetch-enable drop restarts the quiet window.
        if (!csn_s || !fen_s)  state_nxt = ST_WAIT_LOAD;
        else if (cnt == FD_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (eoc_i)        state_nxt = ST_DONE;
        else if (!fen_s)  state_nxt = ST_WAIT_LOAD;
        else if (wdt_hit) state_nxt = ST_TIMEOUT;
      end
      ST_DONE:    state_nxt = ST_DONE;
      ST_TIMEOUT: state_nxt = ST_TIMEOUT;
      default:    state_nxt = ST_RST_HOLD;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        ST_RST_HOLD, ST_FETCH_DELAY: cnt_nxt = cnt + CNT_ONE;
`ifdef BOOT_SEQ_WDT_EN
        ST_RUN: if (cnt != '1) cnt_nxt = cnt + CNT_ONE;
`endif
        default: cnt_nxt = cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RST_HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are decoded from the next state and registered, so they change on the
  // same edge as state_o and never see a combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_n_o   <= 1'b0;
      fetch_enable_o <= 1'b0;
      eoc_o          <= 1'b0;
    end else begin
      core_rst_n_o   <= (state_nxt != ST_RST_HOLD);
      fetch_enable_o <= (state_nxt == ST_RUN) || (state_nxt == ST_DONE);
      eoc_o          <= (state_nxt == ST_DONE);
    end
  end

`ifdef BOOT_SEQ_WDT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_o <= 1'b0;
    else        timeout_o <= (state_nxt == ST_TIMEOUT);
  end
`else
  assign timeout_o = 1'b0;
`endif

  assign state_o = state;

endmodule

// File: tb/tb_pad_boot_sequencer.sv
module tb_pad_boot_sequencer;

  localparam int RST_HOLD    = 16;
  localparam int FETCH_DELAY = 500;
  localparam int WDT_W       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int BOUND       = 3000;

  // State encodings as defined for state_o.
  localparam logic [2:0] S_RST_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_FDELAY   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_TIMEOUT  = 3'd5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fetch_en_pad_i;
  logic             spi_cs_n_i;
  logic             eoc_i;
  logic [WDT_W-1:0] wdt_limit_i;
  logic             core_rst_n_o;
  logic             fetch_enable_o;
  logic             eoc_o;
  logic             timeout_o;
  logic [2:0]       state_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pad_boot_sequencer #(
    .RST_HOLD_CYCLES   (RST_HOLD),
    .FETCH_DELAY_CYCLES(FETCH_DELAY),
    .WDT_WIDTH         (WDT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_pad_i(fetch_en_pad_i),
    .spi_cs_n_i    (spi_cs_n_i),
    .eoc_i         (eoc_i),
    .wdt_limit_i   (wdt_limit_i),
    .core_rst_n_o  (core_rst_n_o),
    .fetch_enable_o(fetch_enable_o),
    .eoc_o         (eoc_o),
    .timeout_o     (timeout_o),
    .state_o       (state_o)
  );

  // Reference timing model: edge counts derived from the boot rules.
  function automatic int ref_release_edges();
    return RST_HOLD;
  endfunction
  // Pad change -> synchroniser -> one FSM edge to react.
  function automatic int ref_pad_react_edges();
    return SYNC_STAGES + 1;
  endfunction
  // Pad rise in WAIT_LOAD -> fetch enable.
  function automatic int ref_boot_edges();
    return ref_pad_react_edges() + FETCH_DELAY;
  endfunction
  // Release of rst_n with pads already ready -> fetch enable.
  function automatic int ref_cold_boot_edges();
    int ready_at;
    ready_at = (RST_HOLD > SYNC_STAGES) ? RST_HOLD : SYNC_STAGES;
    return ready_at + 1 + FETCH_DELAY;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_reset();
    rst_n          = 1'b0;
    fetch_en_pad_i = 1'b0;
    spi_cs_n_i     = 1'b1;
    eoc_i          = 1'b0;
    wdt_limit_i    = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Navigation only: reset, then a clean boot into RUN (cnt=0 on return).
  task automatic boot_to_run();
    go_reset();
    repeat (ref_release_edges()) tick();
    fetch_en_pad_i = 1'b1;
    repeat (ref_boot_edges()) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({core_rst_n_o, fetch_enable_o, eoc_o, timeout_o, state_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b",
               {core_rst_n_o, fetch_enable_o, eoc_o, timeout_o, state_o}, 7'b0);
    end
  endtask

  task automatic test_reset_release();
    int n;
    int idle;
    go_reset();
    n = 0;
    while (core_rst_n_o !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (n != ref_release_edges()) begin
      miscompares++;
      $display("FAIL release_edges: got %0d want %0d", n, ref_release_edges());
    end
    idle = $urandom_range(1, 60);
    repeat (idle) tick();
    vectors++;
    if (state_o !== S_WAIT || fetch_enable_o !== 1'b0) begin
      miscompares++;
      $display("FAIL release_idle: state %0d fe %b want state %0d fe 0", state_o, fetch_enable_o, S_WAIT);
    end
  endtask

  task automatic test_boot();
    int n;
    int pre;
    go_reset();
    pre = $urandom_range(0, 40);
    repeat (ref_release_edges() + pre) tick();
    fetch_en_pad_i = 1'b1;
    n = 0;
    while (fetch_enable_o !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (n != ref_boot_edges()) begin
      miscompares++;
      $display("FAIL boot_edges: got %0d want %0d", n, ref_boot_edges());
    end
    vectors++;
    if (state_o !== S_RUN) begin
      miscompares++;
      $display("FAIL boot_state: got %0d want %0d", state_o, S_RUN);
    end
  endtask

  task automatic test_spi_abort(input int k);
    int n;
    go_reset();
    repeat (ref_release_edges()) tick();
    fetch_en_pad_i = 1'b1;
    repeat (ref_pad_react_edges()) tick();
    repeat (k) tick();
    vectors++;
    if (state_o !== S_FDELAY) begin
      miscompares++;
      $display("FAIL abort_pre_state k=%0d: got %0d want %0d", k, state_o, S_FDELAY);
    end
    spi_cs_n_i = 1'b0;
    repeat (ref_pad_react_edges()) tick();
    vectors++;
    if (state_o !== S_WAIT) begin
      miscompares++;
      $display("FAIL abort_state k=%0d: got %0d want %0d", k, state_o, S_WAIT);
    end
    repeat (4 - ref_pad_react_edges()) tick();
    spi_cs_n_i = 1'b1;
    n = 0;
    while (fetch_enable_o !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (n != ref_boot_edges()) begin
      miscompares++;
      $display("FAIL abort_restart_edges k=%0d: got %0d want %0d", k, n, ref_boot_edges());
    end
  endtask

  task automatic test_eoc();
    int r;
    boot_to_run();
    r = $urandom_range(0, 80);
    repeat (r) tick();
    eoc_i = 1'b1;
    tick();
    eoc_i = 1'b0;
    vectors++;
    if (state_o !== S_DONE || eoc_o !== 1'b1 || fetch_enable_o !== 1'b1) begin
      miscompares++;
      $display("FAIL eoc_enter: state %0d eoc %b fe %b want 4 1 1", state_o, eoc_o, fetch_enable_o);
    end
    fetch_en_pad_i = 1'b0;
    repeat ($urandom_range(5, 30)) tick();
    vectors++;
    if (state_o !== S_DONE || eoc_o !== 1'b1 || fetch_enable_o !== 1'b1) begin
      miscompares++;
      $display("FAIL eoc_sticky: state %0d eoc %b fe %b want 4 1 1", state_o, eoc_o, fetch_enable_o);
    end
  endtask

  task automatic test_eoc_ignored();
    go_reset();
    repeat (ref_release_edges()) tick();
    eoc_i = 1'b1;
    repeat ($urandom_range(2, 10)) tick();
    eoc_i = 1'b0;
    tick();
    vectors++;
    if (state_o !== S_WAIT || eoc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL eoc_ignored: state %0d eoc %b want 1 0", state_o, eoc_o);
    end
  endtask

  task automatic test_fen_drop();
    int n;
    boot_to_run();
    repeat ($urandom_range(0, 50)) tick();
    fetch_en_pad_i = 1'b0;
    repeat (ref_pad_react_edges() - 1) tick();
    vectors++;
    if (fetch_enable_o !== 1'b1) begin
      miscompares++;
      $display("FAIL fen_drop_early: got %b want 1", fetch_enable_o);
    end
    tick();
    vectors++;
    if (fetch_enable_o !== 1'b0 || state_o !== S_WAIT) begin
      miscompares++;
      $display("FAIL fen_drop: fe %b state %0d want 0 %0d", fetch_enable_o, state_o, S_WAIT);
    end
    fetch_en_pad_i = 1'b1;
    n = 0;
    while (fetch_enable_o !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (n != ref_boot_edges()) begin
      miscompares++;
      $display("FAIL fen_reboot_edges: got %0d want %0d", n, ref_boot_edges());
    end
  endtask

`ifdef BOOT_SEQ_WDT_EN
  task automatic test_watchdog(input int lim);
    boot_to_run();
    wdt_limit_i = WDT_W'(lim);
    repeat (lim - 1) tick();
    vectors++;
    if (state_o !== S_RUN) begin
      miscompares++;
      $display("FAIL wdt_pre lim=%0d: got %0d want %0d", lim, state_o, S_RUN);
    end
    tick();
    vectors++;
    if (state_o !== S_TIMEOUT || timeout_o !== 1'b1 || fetch_enable_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wdt_hit lim=%0d: state %0d to %b fe %b want 5 1 0", lim, state_o, timeout_o, fetch_enable_o);
    end
    eoc_i = 1'b1;
    tick();
    eoc_i = 1'b0;
    repeat (5) tick();
    vectors++;
    if (state_o !== S_TIMEOUT || timeout_o !== 1'b1 || eoc_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wdt_sticky: state %0d to %b eoc %b want 5 1 0", state_o, timeout_o, eoc_o);
    end
  endtask

  task automatic test_watchdog_vs_eoc(input int lim);
    boot_to_run();
    wdt_limit_i = WDT_W'(lim);
    repeat (lim - 1) tick();
    eoc_i = 1'b1;
    tick();
    eoc_i = 1'b0;
    vectors++;
    if (state_o !== S_DONE || timeout_o !== 1'b0 || eoc_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wdt_vs_eoc lim=%0d: state %0d to %b eoc %b want 4 0 1", lim, state_o, timeout_o, eoc_o);
    end
  endtask

  task automatic test_watchdog_disabled_or_changed();
    boot_to_run();
    wdt_limit_i = '0;
    repeat (400) tick();
    vectors++;
    if (state_o !== S_RUN || timeout_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wdt_zero: state %0d to %b want 3 0", state_o, timeout_o);
    end
    // Limit lowered mid-run: expiry at the new total RUN cycle count.
    boot_to_run();
    wdt_limit_i = 32'd200;
    repeat (50) tick();
    wdt_limit_i = 32'd60;
    repeat (9) tick();
    vectors++;
    if (state_o !== S_RUN) begin
      miscompares++;
      $display("FAIL wdt_change_pre: got %0d want %0d", state_o, S_RUN);
    end
    tick();
    vectors++;
    if (state_o !== S_TIMEOUT || timeout_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wdt_change_hit: state %0d to %b want 5 1", state_o, timeout_o);
    end
  endtask
`else
  task automatic test_watchdog_absent();
    int lim;
    boot_to_run();
    lim = $urandom_range(1, 200);
    wdt_limit_i = WDT_W'(lim);
    repeat (lim + 50) tick();
    vectors++;
    if (state_o !== S_RUN || timeout_o !== 1'b0 || fetch_enable_o !== 1'b1) begin
      miscompares++;
      $display("FAIL wdt_absent lim=%0d: state %0d to %b fe %b want 3 0 1", lim, state_o, timeout_o, fetch_enable_o);
    end
  endtask
`endif

  task automatic test_mid_reset();
    int n;
    boot_to_run();
    eoc_i = 1'b0;
    repeat ($urandom_range(1, 40)) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({core_rst_n_o, fetch_enable_o, eoc_o, timeout_o, state_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got %b want %b",
               {core_rst_n_o, fetch_enable_o, eoc_o, timeout_o, state_o}, 7'b0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (fetch_enable_o !== 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    vectors++;
    if (n != ref_cold_boot_edges()) begin
      miscompares++;
      $display("FAIL mid_reset_replay: got %0d want %0d", n, ref_cold_boot_edges());
    end
  endtask

  initial begin
    go_reset();
    test_reset();
    test_reset_release();
    test_boot();
    test_spi_abort(250);
    test_spi_abort($urandom_range(0, FETCH_DELAY - 5));
    test_spi_abort($urandom_range(0, FETCH_DELAY - 5));
    test_eoc();
    test_eoc_ignored();
    test_fen_drop();
`ifdef BOOT_SEQ_WDT_EN
    test_watchdog(100);
    test_watchdog($urandom_range(1, 300));
    test_watchdog_vs_eoc(100);
    test_watchdog_disabled_or_changed();
`else
    test_watchdog_absent();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
